// File: rtl/dma_dim2_pkg.sv
// Shared types and constants for the 2-D DMA address generator.
// Imported by dma_dim2 and dma_dim2_cnt.
package dma_dim2_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int AW_DEF = 14;

endpackage

// File: rtl/dma_dim2_cnt.sv
// Size-loaded down-counter; reloads itself when decremented at zero.
// o_term flags the current last count, o_nxt_term the one after a decrement.
module dma_dim2_cnt
  import dma_dim2_pkg::*;
#(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_size,
  input  logic         i_dec,
  output logic         o_term,
  output logic         o_nxt_term
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_rld;
  logic [W-1:0] w_ld;

  // A size of zero behaves like a size of one
  assign w_ld = (i_size == '0) ? '0 : i_size - W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_rld <= '0;
    end else if (i_load) begin
      r_cnt <= w_ld;
      r_rld <= w_ld;
    end else if (i_dec) begin
      r_cnt <= (r_cnt == '0) ? r_rld : r_cnt - W'(1);
    end
  end

  assign o_term     = (r_cnt == '0);
  assign o_nxt_term = o_term ? (r_rld == '0)
                             : (r_cnt == W'(1));

endmodule

// File: rtl/dma_dim2.sv
// 2-D strided address generator with valid/ready beat output.
// DMA_DIM2_ROW_FLAGS_EN: s_first/s_last mark every row, not the transfer.
module dma_dim2
  import dma_dim2_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] base,
  input  logic [6:0]    dim0_size,
  input  logic          dim0_step,
  input  logic [4:0]    dim1_size,
  input  logic [6:0]    dim1_step,
  input  logic          start_valid,
  output logic          start_ready,
  output logic [AW-1:0] s_addr,
  output logic          s_first,
  output logic          s_last,
  output logic          s_valid,
  input  logic          s_ready
);

  state_t r_state;
  state_t w_state_nxt;

  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_row;
  logic          r_first;
  logic          r_last;
  logic          r_valid;
  logic          r_s0;
  logic [6:0]    r_s1;

  logic          w_acc;
  logic          w_hs;
  logic          w_end;
  logic          w_adv;
  logic          w_t0;
  logic          w_t1;
  logic          w_nz0;
  logic          w_nz1;
  logic          w_nz1_raw;
  logic          w_first_nxt;
  logic          w_last_nxt;
  logic          w_last_ld;
  logic [AW-1:0] w_row_nxt;

  assign start_ready = (r_state == IDLE);
  assign w_acc = start_valid && start_ready;
  assign w_hs  = r_valid && s_ready;
  assign w_end = w_hs && w_t0 && w_t1;
  assign w_adv = w_hs && !w_end;

  dma_dim2_cnt #(.W(7)) u_cnt0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_acc),
    .i_size     (dim0_size),
    .i_dec      (w_adv),
    .o_term     (w_t0),
    .o_nxt_term (w_nz0)
  );

  dma_dim2_cnt #(.W(5)) u_cnt1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_acc),
    .i_size     (dim1_size),
    .i_dec      (w_adv && w_t0),
    .o_term     (w_t1),
    .o_nxt_term (w_nz1_raw)
  );

  // Row counter only moves at row ends
  assign w_nz1 = w_t0 ? w_nz1_raw : w_t1;
  assign w_row_nxt = r_row + AW'(r_s1);

`ifdef DMA_DIM2_ROW_FLAGS_EN
  assign w_first_nxt = w_t0;
  assign w_last_nxt  = w_nz0;
  assign w_last_ld   = (dim0_size <= 7'd1);
`else
  assign w_first_nxt = 1'b0;
  assign w_last_nxt  = w_nz0 && w_nz1;
  assign w_last_ld   = (dim0_size <= 7'd1) &&
                       (dim1_size <= 5'd1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_acc) w_state_nxt = BUSY;
      BUSY: if (w_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_row   <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
      r_s0    <= 1'b0;
      r_s1    <= '0;
    end else if (w_acc) begin
      r_addr  <= base;
      r_row   <= base;
      r_s0    <= dim0_step;
      r_s1    <= dim1_step;
      r_valid <= 1'b1;
      r_first <= 1'b1;
      r_last  <= w_last_ld;
    end else if (w_end) begin
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_adv) begin
      if (w_t0) begin
        r_row  <= w_row_nxt;
        r_addr <= w_row_nxt;
      end else begin
        r_addr <= r_addr + AW'(r_s0);
      end
      r_first <= w_first_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign s_addr  = r_addr;
  assign s_first = r_first;
  assign s_last  = r_last;
  assign s_valid = r_valid;

endmodule

// File: tb/tb_dma_dim2.sv
// Scoreboard bench for dma_dim2: expected beats queued at issue,
// a negedge monitor pops and compares on every handshake.
module tb_dma_dim2;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] base = '0;
  logic [6:0]    dim0_size = '0;
  logic          dim0_step = 1'b0;
  logic [4:0]    dim1_size = '0;
  logic [6:0]    dim1_step = '0;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [AW-1:0] s_addr;
  logic          s_first;
  logic          s_last;
  logic          s_valid;
  logic          s_ready = 1'b1;

  typedef struct packed {
    logic [AW-1:0] a;
    logic          f;
    logic          l;
  } beat_t;

  beat_t q[$];
  int    checks = 0;
  int    errors = 0;
  bit    rnd = 1'b0;
  bit    stall = 1'b0;
  beat_t prv;

  dma_dim2 #(.AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .base        (base),
    .dim0_size   (dim0_size),
    .dim0_step   (dim0_step),
    .dim1_size   (dim1_size),
    .dim1_step   (dim1_step),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .s_addr      (s_addr),
    .s_first     (s_first),
    .s_last      (s_last),
    .s_valid     (s_valid),
    .s_ready     (s_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    s_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall) begin
        chk("hold_addr", int'(s_addr), int'(prv.a));
        chk("hold_first", int'(s_first), int'(prv.f));
        chk("hold_last", int'(s_last), int'(prv.l));
        chk("hold_valid", int'(s_valid), 1);
      end
      if (s_valid && s_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", int'(s_addr), -1);
        end else begin
          beat_t e;
          e = q.pop_front();
          chk("addr", int'(s_addr), int'(e.a));
          chk("first", int'(s_first), int'(e.f));
          chk("last", int'(s_last), int'(e.l));
        end
      end
      stall = s_valid && !s_ready;
      prv = '{a: s_addr, f: s_first, l: s_last};
    end else begin
      stall = 1'b0;
    end
  end

  task automatic push_beat(input int a, input bit f, input bit l);
    beat_t b;
    b.a = AW'(a);
    b.f = f;
    b.l = l;
    q.push_back(b);
  endtask

  task automatic push_model(input int b, input int c0, input int st0,
                            input int r1, input int st1);
    int c;
    int r;
    c = (c0 == 0) ? 1 : c0;
    r = (r1 == 0) ? 1 : r1;
    for (int j = 0; j < r; j++)
      for (int i = 0; i < c; i++) begin
`ifdef DMA_DIM2_ROW_FLAGS_EN
        push_beat((b + i * st0 + j * st1) % 16384, i == 0, i == c - 1);
`else
        push_beat((b + i * st0 + j * st1) % 16384,
                  i == 0 && j == 0, i == c - 1 && j == r - 1);
`endif
      end
  endtask

  task automatic issue(input int b, input int c0, input int st0,
                       input int r1, input int st1, input bit keep);
    int n;
    base = AW'(b);
    dim0_size = 7'(c0);
    dim0_step = 1'(st0);
    dim1_size = 5'(r1);
    dim1_step = 7'(st1);
    start_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!start_ready && n < 500);
    if (!start_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep) start_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_left", q.size(), 0);
    @(negedge clk);
    #1;
    chk("end_valid", int'(s_valid), 0);
    chk("end_ready", int'(start_ready), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    #2;
    chk("rst_valid", int'(s_valid), 0);
    chk("rst_addr", int'(s_addr), 0);
    chk("rst_first", int'(s_first), 0);
    chk("rst_last", int'(s_last), 0);
    chk("rst_ready", int'(start_ready), 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 9x5 block, row pitch 10; inputs scrambled after acceptance
    push_model(0, 9, 1, 5, 10);
    issue(0, 9, 1, 5, 10, 1'b0);
    base = 14'd777;
    dim0_size = 7'd2;
    dim1_size = 5'd3;
    dim1_step = 7'd1;
    drain();

    // start held through BUSY
    push_model(100, 5, 1, 2, 20);
    push_model(100, 5, 1, 2, 20);
    issue(100, 5, 1, 2, 20, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!start_ready && n < 200);
    chk("held_gap_ready", int'(start_ready), 1);
    chk("held_gap_valid", int'(s_valid), 0);
    chk("held_gap_q", q.size(), 10);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    drain();

    // random backpressure
    rnd = 1'b1;
    push_model(0, 9, 1, 5, 10);
    issue(0, 9, 1, 5, 10, 1'b0);
    drain();
    rnd = 1'b0;

    // zero inner step
`ifdef DMA_DIM2_ROW_FLAGS_EN
    push_beat(5, 1, 0); push_beat(5, 0, 0); push_beat(5, 0, 1);
    push_beat(12, 1, 0); push_beat(12, 0, 0); push_beat(12, 0, 1);
`else
    push_beat(5, 1, 0); push_beat(5, 0, 0); push_beat(5, 0, 0);
    push_beat(12, 0, 0); push_beat(12, 0, 0); push_beat(12, 0, 1);
`endif
    issue(5, 3, 0, 2, 7, 1'b0);
    drain();

    // zero sizes -> single beat
    push_beat(42, 1, 1);
    issue(42, 0, 1, 0, 9, 1'b0);
    drain();

    // address wrap
    push_beat(16380, 1, 0); push_beat(16381, 0, 0);
    push_beat(16382, 0, 0); push_beat(16383, 0, 0);
    push_beat(0, 0, 0);     push_beat(1, 0, 1);
    issue(16380, 6, 1, 1, 0, 1'b0);
    drain();

    // reset mid-transfer
    push_model(0, 9, 1, 5, 10);
    issue(0, 9, 1, 5, 10, 1'b0);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(s_valid), 0);
    chk("mid_rst_addr", int'(s_addr), 0);
    chk("mid_rst_first", int'(s_first), 0);
    chk("mid_rst_last", int'(s_last), 0);
    chk("mid_rst_ready", int'(start_ready), 1);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_model(0, 9, 1, 5, 10);
    issue(0, 9, 1, 5, 10, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_dim2.md
DMA_DIM2 -- requirements
Module: dma_dim2

Interface
REQ-001 SHALL have parameter AW, default 14: address width of base and s_addr.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port base, input, AW: start address.
REQ-005 SHALL have port dim0_size, input, 7: beats per row.
REQ-006 SHALL have port dim0_step, input, 1: address increment between beats in a row.
REQ-007 SHALL have port dim1_size, input, 5: number of rows.
REQ-008 SHALL have port dim1_step, input, 7: address increment between row starts.
REQ-009 SHALL have port start_valid, input, 1: command request.
REQ-010 SHALL have port start_ready, output, 1: command accept; high only in IDLE.
REQ-011 SHALL have port s_addr, output, AW: generated address.
REQ-012 SHALL have port s_first, output, 1: first-beat marker.
REQ-013 SHALL have port s_last, output, 1: last-beat marker.
REQ-014 SHALL have port s_valid, output, 1: beat valid.
REQ-015 SHALL have port s_ready, input, 1: downstream accept.

Function
REQ-016 SHALL implement two states: IDLE and BUSY.
REQ-017 SHALL, in IDLE, on start_valid && start_ready, latch base/sizes/steps and enter BUSY; s_valid rises the next cycle.
REQ-018 SHALL generate beat (j,i), j=row 0..R-1 outer, i=0..C-1 inner, at s_addr = base + i*dim0_step + j*dim1_step, modulo 2^AW (zero-extend steps, silent wrap).
REQ-019 SHALL treat dim0_size==0 as C=1 and dim1_size==0 as R=1.
REQ-020 SHALL register s_addr, s_valid, s_first and s_last; while s_valid && !s_ready all of them hold stable.
REQ-021 SHALL advance one beat per cycle while s_ready is high (no bubbles).
REQ-022 SHALL assert s_first only on beat (0,0) and s_last only on beat (R-1,C-1) by default; both on a single-beat transfer.
REQ-023 SHALL return to IDLE in the cycle after the s_last handshake, deasserting s_valid; a start_valid held during BUSY is accepted in that IDLE cycle.
REQ-024 SHALL ignore input configuration changes after acceptance.
REQ-025 SHALL drive start_ready combinationally from state (1 in IDLE, 0 in BUSY).

Reset
REQ-026 SHALL, on rst_n low at any time including mid-transfer, force IDLE, s_valid=0, s_first=0, s_last=0, s_addr=0, counters=0; start_ready=1.

Configuration
REQ-027 SHALL, with DMA_DIM2_ROW_FLAGS_EN defined, assert s_first on the first beat of every row and s_last on the last beat of every row; without it, REQ-022 applies.

Structure
REQ-028 SHALL place the state enum and default AW constant in package dma_dim2_pkg.
REQ-029 SHALL use one sub-module dma_dim2_cnt (size-loaded down-counter with terminal flag), instantiated for dim0 and dim1.

Verification
REQ-030 SHALL check base=0, dim0_size=9, dim0_step=1, dim1_size=5, dim1_step=10, s_ready=1 -> 45 beats 0..8,10..18,...,40..48; s_first at 0, s_last at 48.
REQ-031 SHALL check start held during BUSY with base=100, dim0_size=5, dim0_step=1, dim1_size=2, dim1_step=20 -> accepted in IDLE cycle after first transfer; addresses 100..104,120..124.
REQ-032 SHALL check random s_ready toggling -> s_addr/flags stable while stalled, sequence identical to REQ-030, no loss or duplication.
REQ-033 SHALL check base=5, dim0_step=0, dim0_size=3, dim1_size=2, dim1_step=7 -> 5,5,5,12,12,12; and dim0_size=0, dim1_size=0 -> single beat at base with s_first=s_last=1.
REQ-034 SHALL check base=16380, dim0_size=6, dim0_step=1, dim1_size=1 -> 16380,16381,16382,16383,0,1.
REQ-035 SHALL check rst_n low mid-transfer -> outputs at reset values immediately; next start produces a clean full sequence.
